// File: rtl/bram_pkg.sv
// ============================================================================
// Module      : bram_pkg
// Description : Shared types and helpers for the bram_sdp_clr block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_pkg;

   typedef enum logic [0:0] {
      ST_READY = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   function automatic int calc_nb(input int dw);
      return dw / 8;
   endfunction

   // Even parity: the stored bit makes the lane plus parity an even count of ones.
   function automatic logic lane_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bram_clr_seq.sv
// ============================================================================
// Module      : bram_clr_seq
// Description : Clear sequencer; walks every word address once, driving zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_clr_seq
   import bram_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int INIT_CLEAR = 1
)
(
   input  logic                  clk,
   input  logic                  RSTn,
   input  logic                  clr_req,
   output logic                  busy,
   output logic                  clr_start,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam clr_state_t            c_rst_state = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
   localparam logic [ADDR_WIDTH-1:0] c_last      = '1;

   clr_state_t            r_state;
   clr_state_t            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= c_rst_state;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      busy        = 1'b0;
      clr_start   = 1'b0;
      case (r_state)
         ST_READY: begin
            w_cnt_nxt = '0;
            if (clr_req) begin
               clr_start   = 1'b1;
               w_state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            busy      = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_last) begin
               w_state_nxt = ST_READY;
            end
         end
         default: w_state_nxt = ST_READY;
      endcase
   end

   assign clr_we   = busy;
   assign clr_addr = r_cnt;

endmodule

`default_nettype wire

// File: rtl/bram_sdp_clr.sv
// ============================================================================
// Module      : bram_sdp_clr
// Description : Simple-dual-port block RAM with byte enables, read latency
//               1/2, write-first bypass and a zero-fill clear sequencer.
//               Optional lane parity when BRAM_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_sdp_clr
   import bram_pkg::*;
#(
   parameter  int ADDR_WIDTH   = 14,
   parameter  int DATA_WIDTH   = 32,
   parameter  int READ_LATENCY = 1,
   parameter  int WRITE_FIRST  = 1,
   parameter  int INIT_CLEAR   = 1,
   localparam int NB           = calc_nb(DATA_WIDTH)
)
(
   input  logic                  clk,
   input  logic                  RSTn,
   input  logic                  clr_req,
   output logic                  busy,
   input  logic [NB-1:0]         wea,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [DATA_WIDTH-1:0] dina,
   input  logic                  reb,
   input  logic [ADDR_WIDTH-1:0] addrb,
   output logic [DATA_WIDTH-1:0] doutb,
   output logic                  rvalidb
`ifdef BRAM_PARITY_EN
   ,
   output logic                  perr
`endif
);

   localparam int c_depth = 2**ADDR_WIDTH;

   (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [c_depth];

   logic                  w_clr_start;
   logic                  w_clr_we;
   logic [ADDR_WIDTH-1:0] w_clr_addr;
   logic                  w_gate;
   logic [NB-1:0]         w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_rd_acc;
   logic                  w_coll;
   logic [NB-1:0]         w_byp_lane;

   logic                  r_s1_vld;
   logic [DATA_WIDTH-1:0] r_rd_q;
   logic [NB-1:0]         r_byp_lane;
   logic [DATA_WIDTH-1:0] r_byp_data;
   logic [DATA_WIDTH-1:0] w_byp_bits;
   logic [DATA_WIDTH-1:0] w_s1_data;

   bram_clr_seq #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_CLEAR (INIT_CLEAR)
   ) u_clr_seq (
      .clk       (clk),
      .RSTn      (RSTn),
      .clr_req   (clr_req),
      .busy      (busy),
      .clr_start (w_clr_start),
      .clr_we    (w_clr_we),
      .clr_addr  (w_clr_addr)
   );

   // Both user ports are locked out while clearing and in the cycle a clear is accepted.
   assign w_gate     = busy | w_clr_start;
   assign w_we       = w_clr_we ? '1 : (w_gate ? '0 : wea);
   assign w_waddr    = w_clr_we ? w_clr_addr : addra;
   assign w_wdata    = w_clr_we ? '0 : dina;
   assign w_rd_acc   = reb & ~w_gate;
   assign w_coll     = w_rd_acc & (|wea) & (addra == addrb);
   assign w_byp_lane = ((WRITE_FIRST != 0) && w_coll) ? wea : '0;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (w_we[i]) begin
            r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   // Array read register plus the lanes to overlay from a same-cycle write.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_s1_vld   <= 1'b0;
         r_rd_q     <= '0;
         r_byp_lane <= '0;
         r_byp_data <= '0;
      end else begin
         r_s1_vld <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_q     <= r_mem[addrb];
            r_byp_lane <= w_byp_lane;
            r_byp_data <= dina;
         end
      end
   end

   always_comb begin
      w_byp_bits = '0;
      for (int i = 0; i < NB; i++) begin
         w_byp_bits[8*i +: 8] = {8{r_byp_lane[i]}};
      end
   end

   assign w_s1_data = (r_rd_q & ~w_byp_bits) | (r_byp_data & w_byp_bits);

`ifdef BRAM_PARITY_EN
   (* ram_style = "block" *) logic [NB-1:0] r_par [c_depth];

   logic [NB-1:0] w_wpar;
   logic [NB-1:0] w_byp_par;
   logic [NB-1:0] r_par_q;
   logic [NB-1:0] r_byp_par;
   logic [NB-1:0] w_s1_calc;
   logic [NB-1:0] w_s1_par;
   logic          w_s1_perr;

   always_comb begin
      w_wpar    = '0;
      w_byp_par = '0;
      w_s1_calc = '0;
      for (int i = 0; i < NB; i++) begin
         w_wpar[i]    = lane_parity(w_wdata[8*i +: 8]);
         w_byp_par[i] = lane_parity(dina[8*i +: 8]);
         w_s1_calc[i] = lane_parity(w_s1_data[8*i +: 8]);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (w_we[i]) begin
            r_par[w_waddr][i] <= w_wpar[i];
         end
      end
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_par_q   <= '0;
         r_byp_par <= '0;
      end else if (w_rd_acc) begin
         r_par_q   <= r_par[addrb];
         r_byp_par <= w_byp_par;
      end
   end

   assign w_s1_par  = (r_par_q & ~r_byp_lane) | (r_byp_par & r_byp_lane);
   assign w_s1_perr = r_s1_vld & (w_s1_par != w_s1_calc);
`endif

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         always_ff @(posedge clk or negedge RSTn) begin
            if (!RSTn) begin
               doutb   <= '0;
               rvalidb <= 1'b0;
            end else begin
               rvalidb <= r_s1_vld;
               if (r_s1_vld) begin
                  doutb <= w_s1_data;
               end
            end
         end
`ifdef BRAM_PARITY_EN
         always_ff @(posedge clk or negedge RSTn) begin
            if (!RSTn) begin
               perr <= 1'b0;
            end else begin
               perr <= w_s1_perr;
            end
         end
`endif
      end else begin : g_lat1
         // Source registers only load on an accepted read, so doutb holds between reads.
         assign doutb   = w_s1_data;
         assign rvalidb = r_s1_vld;
`ifdef BRAM_PARITY_EN
         assign perr    = w_s1_perr;
`endif
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bram_sdp_clr.sv
// ============================================================================
// Module      : tb_bram_sdp_clr
// Description : Directed self-checking bench for bram_sdp_clr (two configurations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_sdp_clr;

   logic        clk;
   logic        RSTn;

   logic        clr_req1, busy1, reb1, rvalidb1;
   logic [3:0]  wea1;
   logic [13:0] addra1, addrb1;
   logic [31:0] dina1, doutb1;

   logic        clr_req2, busy2, reb2, rvalidb2;
   logic [3:0]  wea2;
   logic [3:0]  addra2, addrb2;
   logic [31:0] dina2, doutb2;

`ifdef BRAM_PARITY_EN
   logic        perr1, perr2;
`endif

   int n_assert;
   int n_fail;
   int cnt;

   bram_sdp_clr u_dut (
      .clk     (clk),
      .RSTn    (RSTn),
      .clr_req (clr_req1),
      .busy    (busy1),
      .wea     (wea1),
      .addra   (addra1),
      .dina    (dina1),
      .reb     (reb1),
      .addrb   (addrb1),
      .doutb   (doutb1),
      .rvalidb (rvalidb1)
`ifdef BRAM_PARITY_EN
      ,
      .perr    (perr1)
`endif
   );

   bram_sdp_clr #(
      .ADDR_WIDTH   (4),
      .DATA_WIDTH   (32),
      .READ_LATENCY (2),
      .WRITE_FIRST  (0),
      .INIT_CLEAR   (0)
   ) u_dut2 (
      .clk     (clk),
      .RSTn    (RSTn),
      .clr_req (clr_req2),
      .busy    (busy2),
      .wea     (wea2),
      .addra   (addra2),
      .dina    (dina2),
      .reb     (reb2),
      .addrb   (addrb2),
      .doutb   (doutb2),
      .rvalidb (rvalidb2)
`ifdef BRAM_PARITY_EN
      ,
      .perr    (perr2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle;
      clr_req1 = 0; wea1 = 0; reb1 = 0;
      clr_req2 = 0; wea2 = 0; reb2 = 0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      RSTn = 0;
      idle();
      addra1 = 0; addrb1 = 0; dina1 = 0;
      addra2 = 0; addrb2 = 0; dina2 = 0;
      tick(); tick();

      // Reset state
      chk("rst_busy1", busy1, 1);
      chk("rst_rvalid1", rvalidb1, 0);
      chk("rst_dout1", doutb1, 0);
      chk("rst_busy2", busy2, 0);
      chk("rst_rvalid2", rvalidb2, 0);
      chk("rst_dout2", doutb2, 0);

      // Test 1: power-up clear length and a read of the top word
      RSTn = 1;
      cnt = 0;
      while (busy1 && cnt < 20000) begin
         tick();
         cnt++;
      end
      chk("init_clear_len", cnt, 16384);
      reb1 = 1; addrb1 = 14'h3FFF;
      tick();
      reb1 = 0;
      chk("rd3fff_vld", rvalidb1, 1);
      chk("rd3fff_data", doutb1, 32'h0);
      tick();
      chk("rvalid_pulse", rvalidb1, 0);

      // Test 2: full write then single-lane overwrite
      wea1 = 4'hF; addra1 = 5; dina1 = 32'hDEADBEEF;
      tick();
      wea1 = 4'h2; dina1 = 32'h00001200;
      tick();
      wea1 = 0; reb1 = 1; addrb1 = 5;
      tick();
      reb1 = 0;
      chk("be_vld", rvalidb1, 1);
      chk("be_data", doutb1, 32'hDEAD12EF);
      tick();
      chk("hold_vld", rvalidb1, 0);
      chk("hold_data", doutb1, 32'hDEAD12EF);

      // Test 3: same-address collision, write-first (dut1) and read-first (dut2)
      wea1 = 4'hF; addra1 = 7; dina1 = 32'hAAAAAAAA;
      wea2 = 4'hF; addra2 = 7; dina2 = 32'hAAAAAAAA;
      tick();
      wea1 = 4'h3; dina1 = 32'h11223344; reb1 = 1; addrb1 = 7;
      wea2 = 4'h3; dina2 = 32'h11223344; reb2 = 1; addrb2 = 7;
      tick();
      idle();
      chk("wf1_vld", rvalidb1, 1);
      chk("wf1_data", doutb1, 32'hAAAA3344);
      chk("wf0_lat2_early", rvalidb2, 0);
      tick();
      chk("wf0_vld", rvalidb2, 1);
      chk("wf0_data", doutb2, 32'hAAAAAAAA);
      reb1 = 1; addrb1 = 7;
      tick();
      reb1 = 0;
      chk("wf1_stored", doutb1, 32'hAAAA3344);

      // Test 4: latency-2 back-to-back reads
      for (int i = 0; i < 4; i++) begin
         wea2 = 4'hF; addra2 = 4'(i); dina2 = 32'hC0DE0000 + 32'(i);
         tick();
      end
      wea2 = 0;
      for (int k = 0; k < 6; k++) begin
         reb2 = (k < 4); addrb2 = 4'(k);
         tick();
         if (k == 0 || k == 5) begin
            chk("b2b_idle_vld", rvalidb2, 0);
         end else begin
            chk("b2b_vld", rvalidb2, 1);
            chk("b2b_data", doutb2, 32'hC0DE0000 + 32'(k - 1));
         end
      end
      reb2 = 0;

      // Read in flight completes after a clear starts (latency 2)
      wea2 = 4'hF; addra2 = 9; dina2 = 32'h5A5A5A5A;
      tick();
      wea2 = 0; reb2 = 1; addrb2 = 9;
      tick();
      reb2 = 0; clr_req2 = 1;
      tick();
      clr_req2 = 0;
      chk("inflight_vld", rvalidb2, 1);
      chk("inflight_data", doutb2, 32'h5A5A5A5A);
      chk("inflight_busy", busy2, 1);
      cnt = 0;
      while (busy2 && cnt < 100) begin
         tick();
         cnt++;
      end
      chk("clr2_len", cnt, 16);
      reb2 = 1; addrb2 = 9;
      tick(); tick();
      reb2 = 0;
      chk("clr2_data", doutb2, 32'h0);

`ifdef BRAM_PARITY_EN
      // Test 6: corrupt one stored bit and expect a parity error
      wea1 = 4'hF; addra1 = 3; dina1 = 32'h0F0F0F0F;
      tick();
      wea1 = 0; reb1 = 1; addrb1 = 3;
      tick();
      reb1 = 0;
      chk("par_ok", perr1, 0);
      u_dut.r_mem[3][9] = ~u_dut.r_mem[3][9];
      reb1 = 1;
      tick();
      reb1 = 0;
      chk("par_err_vld", rvalidb1, 1);
      chk("par_err", perr1, 1);
      tick();
      chk("par_idle", perr1, 0);
`endif

      // Test 5: clear request with same-cycle port activity, reset at count 100
      clr_req1 = 1; wea1 = 4'hF; addra1 = 5; dina1 = 32'h12345678; reb1 = 1; addrb1 = 5;
      tick();
      idle();
      chk("clr_busy", busy1, 1);
      chk("clr_rd_ignored", rvalidb1, 0);
      repeat (100) tick();
      RSTn = 0;
      tick();
      RSTn = 1;
      chk("rst_mid_busy", busy1, 1);
      cnt = 0;
      while (busy1 && cnt < 20000) begin
         clr_req1 = (cnt == 50);
         tick();
         cnt++;
      end
      clr_req1 = 0;
      chk("restart_clear_len", cnt, 16384);
      reb1 = 1; addrb1 = 5;
      tick();
      chk("cleared5", doutb1, 32'h0);
      addrb1 = 7;
      tick();
      reb1 = 0;
      chk("cleared7_vld", rvalidb1, 1);
      chk("cleared7", doutb1, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
